apb_cmd_master: RTL and testbench

Single-outstanding APB3 master that turns a valid/ready command stream into APB transfers. Sits directly upstream of the APB register-file slaves. Issues SETUP/ACCESS phases, honours `pready` wait states, returns read data and error status on a valid/ready response channel, and aborts hung transfers with a timeout. Misaligned addresses are rejected locally without a bus cycle.

---
 rtl/apb_cmd_pkg.sv | 25 ++
 rtl/apb_wait_timer.sv | 51 +++++
 rtl/apb_cmd_master.sv | 143 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_pkg.sv
// ============================================================================
// Module      : apb_cmd_pkg
// Description : Shared state encoding and alignment helpers for apb_cmd_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  localparam int APB_ALIGN_BITS = 2;

  function automatic logic is_aligned(input logic [APB_ALIGN_BITS-1:0] lsbs);
    return (lsbs == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_wait_timer.sv
// ============================================================================
// Module      : apb_wait_timer
// Description : Counts pready-low ACCESS cycles and flags when TIMEOUT is hit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  generate
    if (TIMEOUT > 0) begin : g_timer
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (inc && (cnt_q != C_LIMIT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expired = (cnt_q == C_LIMIT);
    end else begin : g_no_timer
      assign expired = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/apb_cmd_master.sv
// ============================================================================
// Module      : apb_cmd_master
// Description : Single-outstanding APB3 master driven by a valid/ready command
//               stream, with response channel, wait-state timeout and
//               local rejection of misaligned addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              timeout_pulse,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_mst_state_t    state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_pulse_q, timeout_pulse_d;
  logic              timer_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q != ACCESS),
    .inc     ((state_q == ACCESS) && !pready),
    .expired (timer_expired)
  );

  always_comb begin
    state_d         = state_q;
    paddr_d         = paddr_q;
    pwrite_d        = pwrite_q;
    pwdata_d        = pwdata_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    timeout_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (is_aligned(cmd_addr[APB_ALIGN_BITS-1:0])) begin
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            pwdata_d = cmd_wdata;
            state_d  = SETUP;
          end else begin
            // Rejected locally: the bus never sees this command.
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A slave completing on the timeout cycle still counts as a normal finish.
        if (pready) begin
          rsp_err_d   = pslverr;
          rsp_rdata_d = (!pwrite_q && !pslverr) ? prdata : '0;
          state_d     = RESP;
        end else if (timer_expired) begin
          rsp_err_d       = 1'b1;
          rsp_rdata_d     = '0;
          timeout_pulse_d = 1'b1;
          state_d         = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      paddr_q         <= '0;
      pwrite_q        <= 1'b0;
      pwdata_q        <= '0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      paddr_q         <= paddr_d;
      pwrite_q        <= pwrite_d;
      pwdata_q        <= pwdata_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign psel          = (state_q == SETUP) || (state_q == ACCESS);
  assign penable       = (state_q == ACCESS);
  assign paddr         = paddr_q;
  assign pwrite        = pwrite_q;
  assign pwdata        = pwdata_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
// ============================================================================
// Module      : tb_apb_cmd_master
// Description : Scoreboard bench for apb_cmd_master with a behavioural APB
//               slave and a transaction-level response model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_cmd_master;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TMO    = 4;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          tmo;
    int          lat;
    int          psel_cyc;
    int          hs;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              timeout_pulse;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rsp_mode = 0;  // 0 random, 1 always ready, 2 held low
  int          slave_waits = 0;
  bit          slave_err = 1'b0;
  logic [31:0] slave_rdata = '0;
  int          acc_cnt = 0;
  exp_t        exp_q[$];
  bit          apb_exp_valid = 1'b0;
  logic [7:0]  apb_addr = '0;
  bit          apb_write = 1'b0;
  logic [31:0] apb_wdata = '0;

  apb_cmd_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .timeout_pulse (timeout_pulse),
    .paddr         (paddr),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .pwdata        (pwdata),
    .prdata        (prdata),
    .pready        (pready),
    .pslverr       (pslverr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: completes after slave_waits pready-low ACCESS cycles.
  always @(posedge clk) begin
    if (psel && penable) acc_cnt <= acc_cnt + 1;
    else                 acc_cnt <= 0;
  end
  assign pready  = psel && penable && (acc_cnt == slave_waits);
  assign pslverr = pready && slave_err;
  assign prdata  = slave_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input bit wr, input logic [7:0] addr, input int waits,
                                 input bit serr, input logic [31:0] rd, input int hs);
    exp_t e;
    e.hs = hs;
    e.tmo = 1'b0;
    if (addr[1:0] != 2'b00) begin
      e.err = 1'b1; e.rdata = '0; e.lat = 1; e.psel_cyc = 0;
    end else if (waits > TMO) begin
      e.err = 1'b1; e.rdata = '0; e.tmo = 1'b1; e.lat = 3 + TMO; e.psel_cyc = TMO + 2;
    end else begin
      e.err = serr; e.rdata = (wr || serr) ? 32'h0 : rd; e.lat = 3 + waits; e.psel_cyc = waits + 2;
    end
    return e;
  endfunction

  task automatic issue(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                       input int waits, input bit serr, input logic [31:0] rd);
    int guard;
    @(negedge clk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept_timeout actual=cmd_ready 0 expected=1");
      cmd_valid = 1'b0;
      return;
    end
    slave_waits = waits; slave_err = serr; slave_rdata = rd;
    exp_q.push_back(model(wr, addr, waits, serr, rd, cyc));
    apb_exp_valid = (addr[1:0] == 2'b00);
    apb_addr = addr; apb_write = wr; apb_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && guard < budget) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
    end
  endtask

  // Response-ready driver, updated just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        1:       rsp_ready = 1'b1;
        2:       rsp_ready = 1'b0;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: APB protocol checks and scoreboard pops on response handshakes.
  initial begin
    bit          prev_psel = 1'b0;
    bit          first = 1'b1;
    int          psel_cnt = 0;
    int          pulse_cnt = 0;
    logic [31:0] hold_rdata = '0;
    bit          hold_err = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_psel = 1'b0; first = 1'b1; psel_cnt = 0; pulse_cnt = 0;
        continue;
      end
      if (timeout_pulse) pulse_cnt++;
      if (psel) begin
        psel_cnt++;
        chk("psel_expected", 32'(apb_exp_valid), 32'd1);
        chk("paddr", 32'(paddr), 32'(apb_addr));
        chk("pwrite", 32'(pwrite), 32'(apb_write));
        if (apb_write) chk("pwdata", pwdata, apb_wdata);
        chk("penable_phase", 32'(penable), 32'(prev_psel));
      end else begin
        chk("penable_without_psel", 32'(penable), 32'd0);
      end
      prev_psel = psel;
      if (rsp_valid) begin
        chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q[0];
          if (first) begin
            first = 1'b0;
            chk("rsp_latency", 32'(cyc - e.hs), 32'(e.lat));
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            hold_rdata = rsp_rdata; hold_err = rsp_err;
          end else begin
            chk("rsp_rdata_stable", rsp_rdata, hold_rdata);
            chk("rsp_err_stable", 32'(rsp_err), 32'(hold_err));
          end
          if (rsp_ready) begin
            chk("psel_cycles", 32'(psel_cnt), 32'(e.psel_cyc));
            chk("timeout_pulses", 32'(pulse_cnt), 32'(e.tmo));
            void'(exp_q.pop_front());
            apb_exp_valid = 1'b0;
            first = 1'b1; psel_cnt = 0; pulse_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    int   guard;
    bit   wr;
    logic [7:0] addr;
    int   waits;
    int   sel;

    #3;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_outputs", {psel, penable, pwrite, rsp_valid, rsp_err, timeout_pulse}, 32'd0);
    chk("reset_buses", {paddr, pwdata, rsp_rdata} == '0 ? 32'd0 : 32'd1, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the test plan.
    rsp_mode = 1;
    issue(1'b1, 8'h08, 32'hDEADBEEF, 0, 1'b0, 32'h12345678);
    issue(1'b0, 8'h1C, 32'h0, 3, 1'b0, 32'h00010000);
    issue(1'b0, 8'h10, 32'h0, 0, 1'b1, 32'h00000055);
    issue(1'b0, 8'h20, 32'h0, 100, 1'b0, 32'hAAAA5555);
    issue(1'b0, 8'h24, 32'h0, 1, 1'b0, 32'hCAFEF00D);
    issue(1'b1, 8'h28, 32'h01020304, TMO, 1'b0, 32'h0);
    issue(1'b0, 8'h2C, 32'h0, TMO, 1'b0, 32'h0BADF00D);
    wait_idle(100);

    // Misaligned command with the response held back.
    rsp_mode = 2;
    issue(1'b0, 8'h06, 32'h0, 0, 1'b0, 32'h77777777);
    repeat (5) @(negedge clk);
    chk("held_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("held_cmd_ready", 32'(cmd_ready), 32'd0);
    rsp_mode = 1;
    wait_idle(50);

    // Randomized traffic.
    rsp_mode = 0;
    for (int i = 0; i < 80; i++) begin
      wr = $urandom_range(0, 1);
      addr = 8'($urandom);
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      sel = $urandom_range(0, 9);
      if (sel < 6)      waits = $urandom_range(0, 3);
      else if (sel < 8) waits = TMO;
      else              waits = TMO + $urandom_range(1, 3);
      issue(wr, addr, $urandom, waits, ($urandom_range(0, 4) == 0), $urandom);
    end
    wait_idle(500);

    // Reset during ACCESS drops the transfer without a response.
    rsp_mode = 1;
    issue(1'b0, 8'h30, 32'h0, 100, 1'b0, 32'h11111111);
    guard = 0;
    while (!penable && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("reached_access", 32'(penable), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    apb_exp_valid = 1'b0;
    #1;
    chk("async_reset_psel_penable", {30'd0, psel, penable}, 32'd0);
    chk("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_addr = 8'h40;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    issue(1'b0, 8'h44, 32'h0, 2, 1'b0, 32'h600DCAFE);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
